// File: rtl/ccff_pkg.sv
// ---------------------------------------------------------------------------
// ccff_pkg
// Shared definitions for the CCFF configuration-chain loader:
//   - ccff_state_e    : loader FSM states (IDLE, LOAD, VERIFY, DONE)
//   - BIT_COUNT_W     : width of the per-pass shift counter
//   - words_per_pass(): host words needed to fill a chain of chain_len bits
// ---------------------------------------------------------------------------
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } ccff_state_e;

  localparam int BIT_COUNT_W = 16;

  // ceil(chain_len / word_w): the last word may be only partly used.
  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// ---------------------------------------------------------------------------
// ccff_word_serializer
// Turns host words into a bit-serial stream for the head of the CCFF chain.
// One word buffer is held; the bit currently on ccff_head is always
// buf_word[buf_idx] while buf_full is set, so a new word can be taken in the
// same cycle its predecessor's last bit is being shifted, giving gap-free
// shifting when the host keeps word_valid high.
//
// Ports:
//   clk, rst_n    : programming clock, asynchronous active-low reset
//   active        : loader is in a shifting pass (LOAD or VERIFY)
//   restart       : begin a new pass (clears buffer and word counter)
//   word_in       : host word, consumed LSB first
//   word_valid    : host offers word_in
//   word_ready    : word_in is accepted this cycle when word_valid is high
//   ccff_head     : registered serial data to the chain head
//   chain_clk_en  : registered chain shift enable
// ---------------------------------------------------------------------------
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 12,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              restart,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_clk_en
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WORDS = words_per_pass(CHAIN_LEN, WORD_W);

  // Last valid bit index of an ordinary word and of the final word of a pass.
  localparam logic [IDX_W-1:0]       FULL_LAST  = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0]       FINAL_LAST = IDX_W'((CHAIN_LEN - 1) % WORD_W);
  localparam logic [BIT_COUNT_W-1:0] FINAL_WORD = BIT_COUNT_W'(WORDS - 1);

  logic [WORD_W-1:0]      buf_word;
  logic [IDX_W-1:0]       buf_idx;
  logic [IDX_W-1:0]       buf_last;
  logic                   buf_full;
  logic [BIT_COUNT_W-1:0] word_cnt;
  logic                   final_taken;

  logic                   on_last;
  logic                   take;
  logic [IDX_W-1:0]       next_idx;
  logic [IDX_W-1:0]       next_last;

  // Handshake and next-bit selection derived from buffer state only.
  always_comb begin
    on_last    = buf_full && (buf_idx == buf_last);
    word_ready = active && !final_taken && (!buf_full || on_last);
    take       = word_ready && word_valid;
    next_idx   = buf_idx + IDX_W'(1);
    if (word_cnt == FINAL_WORD) begin
      next_last = FINAL_LAST;
    end else begin
      next_last = FULL_LAST;
    end
  end

  // Word buffer, bit index, word counter and the chain-facing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_word     <= '0;
      buf_idx      <= '0;
      buf_last     <= '0;
      buf_full     <= 1'b0;
      word_cnt     <= '0;
      final_taken  <= 1'b0;
      ccff_head    <= 1'b0;
      chain_clk_en <= 1'b0;
    end else if (restart) begin
      // ccff_head deliberately holds its value across pass boundaries.
      buf_idx      <= '0;
      buf_last     <= '0;
      buf_full     <= 1'b0;
      word_cnt     <= '0;
      final_taken  <= 1'b0;
      chain_clk_en <= 1'b0;
    end else if (take) begin
      // Bit 0 of the new word goes straight to the head register.
      buf_word     <= word_in;
      buf_idx      <= '0;
      buf_last     <= next_last;
      buf_full     <= 1'b1;
      ccff_head    <= word_in[0];
      chain_clk_en <= 1'b1;
      word_cnt     <= word_cnt + BIT_COUNT_W'(1);
      final_taken  <= (word_cnt == FINAL_WORD);
    end else if (buf_full && !on_last) begin
      buf_idx      <= next_idx;
      ccff_head    <= buf_word[next_idx];
      chain_clk_en <= 1'b1;
    end else begin
      // Buffer drained (or never filled): stall, head keeps its value.
      buf_full     <= 1'b0;
      chain_clk_en <= 1'b0;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
// Writer-side loader for a CCFF configuration chain. A host streams words
// over a valid/ready handshake; they are shifted onto ccff_head with a
// matching chain_clk_en so the chain shifts exactly CHAIN_LEN times per pass.
//
// Optional feature, macro CCFF_CHAIN_LOADER_READBACK_CHECK_EN:
//   adds a VERIFY pass in which the host re-supplies the same bitstream and
//   ccff_tail is compared with ccff_head on every shift; any difference sets
//   the sticky error flag. Without the macro, LOAD goes straight to DONE,
//   error is constant 0 and ccff_tail is ignored.
//
// Ports:
//   prog_clk      : programming clock (only clock)
//   prog_reset_n  : asynchronous active-low reset
//   start         : begin a load, honoured in IDLE or DONE only
//   word_in       : configuration word, LSB shifted first
//   word_valid    : host offers word_in
//   word_ready    : loader accepts word_in this cycle
//   ccff_head     : registered serial data to the chain head
//   chain_clk_en  : registered chain shift enable
//   ccff_tail     : chain output, used for readback checking
//   busy          : load or verify pass in progress
//   done          : held high in DONE
//   bit_count     : shifts completed in the current pass
//   error         : sticky readback mismatch
// ---------------------------------------------------------------------------
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 12,
  parameter int WORD_W    = 8
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset_n,
  input  logic                   start,
  input  logic [WORD_W-1:0]      word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic                   ccff_head,
  output logic                   chain_clk_en,
  input  logic                   ccff_tail,
  output logic                   busy,
  output logic                   done,
  output logic [BIT_COUNT_W-1:0] bit_count,
  output logic                   error
);

  localparam logic [BIT_COUNT_W-1:0] LAST_SHIFT = BIT_COUNT_W'(CHAIN_LEN - 1);

  ccff_state_e state;
  logic        active;
  logic        start_take;
  logic        pass_last;
  logic        restart;

  // Pass control: the final shift of a pass is the enabled cycle in which
  // CHAIN_LEN-1 shifts have already completed.
  always_comb begin
    active     = (state == ST_LOAD) || (state == ST_VERIFY);
    start_take = start && ((state == ST_IDLE) || (state == ST_DONE));
    pass_last  = active && chain_clk_en && (bit_count == LAST_SHIFT);
    restart    = start_take || pass_last;
  end

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_serializer (
    .clk          (prog_clk),
    .rst_n        (prog_reset_n),
    .active       (active),
    .restart      (restart),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .ccff_head    (ccff_head),
    .chain_clk_en (chain_clk_en)
  );

`ifndef CCFF_CHAIN_LOADER_READBACK_CHECK_EN
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign error       = 1'b0;
`endif

  // Loader FSM with registered busy/done/bit_count (and error when checking).
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_count <= '0;
`ifdef CCFF_CHAIN_LOADER_READBACK_CHECK_EN
      error     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_take) begin
            state     <= ST_LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
            bit_count <= '0;
`ifdef CCFF_CHAIN_LOADER_READBACK_CHECK_EN
            error     <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (chain_clk_en) begin
            bit_count <= bit_count + BIT_COUNT_W'(1);
          end
          if (pass_last) begin
`ifdef CCFF_CHAIN_LOADER_READBACK_CHECK_EN
            state     <= ST_VERIFY;
            bit_count <= '0;
`else
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
`endif
          end
        end
`ifdef CCFF_CHAIN_LOADER_READBACK_CHECK_EN
        ST_VERIFY: begin
          if (chain_clk_en) begin
            bit_count <= bit_count + BIT_COUNT_W'(1);
            // The tail presents the bit loaded at this same pass position.
            if (ccff_tail != ccff_head) begin
              error <= 1'b1;
            end
          end
          if (pass_last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          bit_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Bitstream loader for the configuration-chain (CCFF) protocol, on the writer side of the chain.
- Accepts configuration words from a host over a valid/ready handshake and serializes them onto the chain's `ccff_head`.
- Produces the chain clock enable, so the fabric chain shifts exactly `CHAIN_LEN` times per load.
- Sits between the programming interface and the head of the tile/connection-block CCFF chain.
- Optionally re-streams the same bitstream and checks it against the bits returned on `ccff_tail`.

## Interface
Parameters:
- `CHAIN_LEN`, default 12: total configuration bits in the attached chain, range 1 to 65535.
- `WORD_W`, default 8: host word width, range 1 to 32.

Ports:
- `prog_clk` in, 1 bit: programming clock. It is the only clock.
- `prog_reset_n` in, 1 bit: asynchronous, active-low reset.
- `start` in, 1 bit: begins a load. Sampled only in IDLE or DONE.
- `word_in` in, `WORD_W` bits: configuration word, consumed LSB first.
- `word_valid` in, 1 bit: `word_in` is valid.
- `word_ready` out, 1 bit: the loader accepts `word_in` this cycle.
- `ccff_head` out, 1 bit: serial data to the chain head. Registered.
- `chain_clk_en` out, 1 bit: the chain samples `ccff_head` on this cycle's rising edge. Registered.
- `ccff_tail` in, 1 bit: chain output. Used only with the check feature.
- `busy` out, 1 bit: a load or verify is in progress.
- `done` out, 1 bit: level, held in DONE.
- `bit_count` out, 16 bits: number of shifts completed in the current pass.
- `error` out, 1 bit: sticky readback mismatch. Tied to 0 when the check feature is compiled out.

## Operation
States and transitions:
- IDLE → LOAD on `start`.
- LOAD → VERIFY after `CHAIN_LEN` shifts, when the check feature is compiled in.
- LOAD → DONE after `CHAIN_LEN` shifts, when the check feature is compiled out.
- VERIFY → DONE after `CHAIN_LEN` shifts.
- DONE → LOAD on `start`.
- `start` is ignored in LOAD and VERIFY.

Serializer:
- Holds one word buffer and a bit index.
- Each cycle with a bit available: drive that bit on `ccff_head`, assert `chain_clk_en`, increment `bit_count`.
- No bit available (buffer empty and no handshake): `chain_clk_en`=0 and `ccff_head` holds (stall).
- The chain never shifts on a stall cycle.

Word handshake:
- `word_ready`=1 in LOAD/VERIFY when the buffer is empty, or when the last valid bit of the buffer shifts this cycle.
- A word is accepted on `word_valid && word_ready`.
- Number of words per pass is ceil(`CHAIN_LEN`/`WORD_W`).
- In the final word, bits above position (`CHAIN_LEN`-1) mod `WORD_W` are discarded.
- `word_ready`=0 once the final word of a pass has been accepted.

Bit ordering:
- Word 0 bit 0 is the first bit shifted.
- After a completed LOAD it resides in the tail-most chain cell.

Boundary behaviour:
- On entering VERIFY, or when a new `start` arrives from DONE, `bit_count` clears to 0.
- `error` clears on `start`.
- Reset mid-operation returns the FSM to IDLE and clears all outputs. Chain contents are then undefined and the host must reload.

## Timing
- Reset values: `word_ready`=0, `ccff_head`=0, `chain_clk_en`=0, `busy`=0, `done`=0, `bit_count`=0, `error`=0.
- `start` at edge N: LOAD and `busy`=1 from cycle N+1; `word_ready`=1 in cycle N+1.
- Word accepted at edge M: its bit 0 appears on `ccff_head`, with `chain_clk_en`=1, in cycle M+1.
- With `word_valid` held high, shifting is continuous: one bit per cycle with no bubbles between words.
- Last shift of the final pass in cycle L: `done`=1 and `busy`=0 from cycle L+1.
- Each pass takes exactly `CHAIN_LEN` cycles with `chain_clk_en`=1.

## Configuration
Macro `CCFF_CHAIN_LOADER_READBACK_CHECK_EN`.

Defined:
- The VERIFY pass is present. The host re-supplies the identical bitstream.
- In each VERIFY cycle where `chain_clk_en`=1, `ccff_tail` is compared with the bit currently driven on `ccff_head`, i.e. bit k of the pass is compared in pass cycle k.
- Any mismatch sets `error`.
- Re-shifting identical data leaves the chain contents unchanged.

Undefined:
- No VERIFY state; LOAD goes directly to DONE.
- `error` is constant 0 and `ccff_tail` is unused.

## Structure
Shared package `ccff_pkg` holds:
- The state enum: IDLE, LOAD, VERIFY, DONE.
- The `bit_count` width constant (16).
- A function computing words per pass from `CHAIN_LEN` and `WORD_W`.

One sub-module, `ccff_word_serializer`, holds the word buffer, bit index, `word_ready` generation, and the `ccff_head`/`chain_clk_en` registers. The FSM, counters and checker live in the top module.

## Test plan
All scenarios use `CHAIN_LEN`=12 and `WORD_W`=8, against a behavioural 12-bit chain model clocked only when `chain_clk_en`=1.
- Basic load, check compiled out: `start`, then words 0xA5 and 0x0C back-to-back → exactly 12 enable cycles. Chain cells tail→head = 1,0,1,0,0,1,0,1,0,0,1,1. `done`=1 one cycle after the 12th shift. `bit_count`=12.
- Stall: deassert `word_valid` for 3 cycles between the two words → `chain_clk_en` low for those 3 cycles, `ccff_head` held, final chain contents identical to the basic load.
- Readback pass, check compiled in: load 0xA5/0x0C, then re-supply the same words → `error`=0, chain unchanged, `done` after 24 total shifts.
- Readback mismatch, check compiled in: second pass supplies 0xA4/0x0C → `error`=1 from the first VERIFY cycle and sticky; `done` still asserts.
- Reset mid-load: `prog_reset_n` low after 5 shifts → all outputs 0 immediately. `start` is then needed; a full reload shifts exactly 12 bits.
- Protocol corners: `start` during LOAD is ignored. A third word offered after the final word is not accepted (`word_ready`=0). `start` from DONE clears `bit_count` and `error`.
